// File: rtl/edge_to_level_generator.sv
// rtl/edge_to_level_generator.sv - rebuilds a registered level from rise/fall/toggle request pulses
// Minimum high/low hold windows are enforced; one edge arriving inside a hold window is deferred.

module edge_to_level_generator #(
  parameter int   MINIMUM_HIGH_CYCLES = 1,
  parameter int   MINIMUM_LOW_CYCLES  = 1,
  parameter logic RESET_LEVEL         = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic rising_request,
  input  logic falling_request,
  input  logic toggle_request,
  output logic signal,
  output logic busy,
  output logic pending,
  output logic dropped
);

  localparam int MAXIMUM_CYCLES = (MINIMUM_HIGH_CYCLES > MINIMUM_LOW_CYCLES) ?
                                  MINIMUM_HIGH_CYCLES : MINIMUM_LOW_CYCLES;
  localparam int W = (MAXIMUM_CYCLES + 1 > 2) ? $clog2(MAXIMUM_CYCLES + 1) : 1;
  localparam logic [W-1:0] HIGH_LOAD = W'(MINIMUM_HIGH_CYCLES - 1);
  localparam logic [W-1:0] LOW_LOAD  = W'(MINIMUM_LOW_CYCLES - 1);
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] ZERO      = '0;

  logic [W-1:0] count;
  logic [W-1:0] next_count;
  logic         next_signal;
  logic         next_pending;
  logic         next_dropped;
  logic         conflict;
  logic         request_valid;
  logic         reference;
  logic         request_target;
  logic         final_target;

  always_comb begin
    conflict       = rising_request & falling_request;
    request_valid  = ~conflict & (rising_request | falling_request | toggle_request);
    // A stored edge always targets ~signal, so it shifts the level a toggle inverts.
    reference      = pending ? ~signal : signal;
    request_target = rising_request ? 1'b1 : (falling_request ? 1'b0 : ~reference);
    final_target   = request_valid ? request_target : reference;

    next_signal  = signal;
    next_pending = pending;
    next_dropped = conflict;
    next_count   = (count != ZERO) ? (count - ONE) : count;

    if (count == ZERO) begin
      if (final_target != signal) begin
        next_signal  = final_target;
        next_pending = 1'b0;
        next_count   = final_target ? HIGH_LOAD : LOW_LOAD;
      end else if (pending) begin
        next_pending = 1'b0;
        next_dropped = 1'b1;
      end
    end else if (request_valid) begin
      if (request_target != signal) begin
        if (!pending) next_pending = 1'b1;
      end else if (pending) begin
        next_pending = 1'b0;
        next_dropped = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      signal  <= RESET_LEVEL;
      busy    <= 1'b0;
      pending <= 1'b0;
      dropped <= 1'b0;
      count   <= ZERO;
    end else begin
      signal  <= next_signal;
      busy    <= (next_count != ZERO);
      pending <= next_pending;
      dropped <= next_dropped;
      count   <= next_count;
    end
  end

endmodule
